// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core.
// Divider support is compiled in only when MDU_DIV_EN is defined; otherwise div/divu are no-ops.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUop,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               signed_q;
    logic               div_q;

    logic               md_op;
    logic               div_op;
    logic               issue;
    logic               done;

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_write;

    // Decode: which ops occupy the unit for a multi-cycle busy period.
    always_comb begin
        md_op  = 1'b0;
        div_op = 1'b0;
        case (MDUop)
            OP_MULT, OP_MULTU: md_op = 1'b1;
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                md_op  = 1'b1;
                div_op = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign issue     = start && md_op && (state == IDLE);
    assign stall_req = busy || (start && md_op);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state == RUN);
        done = (state == RUN) && (cnt == CNT_W'(1));
    end

    // Busy counter and operand latch.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (reset) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            div_q    <= 1'b0;
        end else if (issue) begin
            cnt      <= div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            a_q      <= srcA;
            b_q      <= srcB;
            signed_q <= (MDUop == OP_MULT) || (MDUop == OP_DIV);
            div_q    <= div_op;
        end else if (state == RUN) begin
            cnt      <= cnt - CNT_W'(1);
        end
    end

    // Multiplier: extend to 2*WIDTH so one product serves both signed and unsigned.
    always_comb begin
        a_ext = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = a_ext * b_ext;
    end

`ifdef MDU_DIV_EN
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

    // Sign-magnitude divide: the quotient truncates toward zero and the remainder follows
    // the dividend. MIN / -1 falls out naturally as MIN with remainder 0.
    always_comb begin
        neg_a   = signed_q && a_q[WIDTH-1];
        neg_b   = signed_q && b_q[WIDTH-1];
        mag_a   = neg_a ? -a_q : a_q;
        mag_b   = neg_b ? -b_q : b_q;
        divisor = (b_q == '0) ? WIDTH'(1) : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        quot    = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem     = neg_a ? -r_mag : r_mag;
    end

    always_comb begin
        if (div_q) begin
            res_hi    = rem;
            res_lo    = quot;
            res_write = (b_q != '0);
        end else begin
            res_hi    = prod[2*WIDTH-1:WIDTH];
            res_lo    = prod[WIDTH-1:0];
            res_write = 1'b1;
        end
    end
`else
    always_comb begin
        res_hi    = prod[2*WIDTH-1:WIDTH];
        res_lo    = prod[WIDTH-1:0];
        res_write = !div_q;
    end
`endif

    // HI/LO: result write on the final busy edge; mthi/mtlo only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            if (res_write) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (start && (state == IDLE)) begin
            if (MDUop == OP_MTHI) hi <= srcA;
            if (MDUop == OP_MTLO) lo <= srcA;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; expectations follow MDU_DIV_EN.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDUop;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef MDU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    mult_div_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MDUop     (MDUop),
        .srcA      (srcA),
        .srcB      (srcB),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle from a negedge, check stall_req before the edge, then scramble live operands.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic exp_stall, input string tag);
        start = 1'b1;
        MDUop = op;
        srcA  = a;
        srcB  = b;
        #1;
        check({tag, "_stall"}, {31'd0, stall_req}, {31'd0, exp_stall});
        @(negedge clk);
        start = 1'b0;
        MDUop = 4'd0;
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    task automatic wait_busy(input int exp_n, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, exp_n);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        MDUop = 4'd0;
        srcA  = '0;
        srcB  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);

        // mult -2 * 3
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult");
        wait_busy(5, "mult");
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // multu same operands
        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1, "multu");
        wait_busy(5, "multu");
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // div -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, DIV_ON, "div");
        if (DIV_ON) begin
            wait_busy(10, "div");
            check("div_hi", hi, 32'hFFFF_FFFF);
            check("div_lo", lo, 32'hFFFF_FFFD);
        end else begin
            check("div_off_busy", {31'd0, busy}, 32'd0);
            check("div_off_hi", hi, 32'h0000_0002);
            check("div_off_lo", lo, 32'hFFFF_FFFA);
        end

        // div most-negative / -1
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_ON, "divovf");
        if (DIV_ON) begin
            wait_busy(10, "divovf");
            check("divovf_hi", hi, 32'h0000_0000);
            check("divovf_lo", lo, 32'h8000_0000);
        end else begin
            check("divovf_off_busy", {31'd0, busy}, 32'd0);
            check("divovf_off_lo", lo, 32'hFFFF_FFFA);
        end

        // mthi / mtlo single cycle
        issue(4'd5, 32'h0000_1234, 32'd0, 1'b0, "mthi");
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(4'd6, 32'h0000_5678, 32'd0, 1'b0, "mtlo");
        check("mtlo_lo", lo, 32'h0000_5678);
        check("mtlo_hi_kept", hi, 32'h0000_1234);

        // divu by zero leaves HI/LO unchanged after a full busy period
        issue(4'd4, 32'hDEAD_BEEF, 32'd0, DIV_ON, "divu0");
        wait_busy(DIV_ON ? 10 : 0, "divu0");
        check("divu0_hi", hi, 32'h0000_1234);
        check("divu0_lo", lo, 32'h0000_5678);

        // divu 100 / 7
        issue(4'd4, 32'd100, 32'd7, DIV_ON, "divu");
        wait_busy(DIV_ON ? 10 : 0, "divu");
        check("divu_hi", hi, DIV_ON ? 32'd2 : 32'h0000_1234);
        check("divu_lo", lo, DIV_ON ? 32'd14 : 32'h0000_5678);

        // mult 7*6 with mtlo hammered while busy, then back-to-back mult
        issue(4'd1, 32'd7, 32'd6, 1'b1, "mult76");
        start = 1'b1;
        MDUop = 4'd6;
        srcA  = 32'h0000_AAAA;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            check("busy_stall", {31'd0, stall_req}, 32'd1);
            @(negedge clk);
        end
        check("mult76_busy_cycles", n, 32'd5);
        check("mult76_hi", hi, 32'd0);
        check("mult76_lo", lo, 32'd42);
        issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "b2b");
        check("b2b_busy_rise", {31'd0, busy}, 32'd1);
        wait_busy(5, "b2b");
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd1);

        // reset in busy cycle 3 aborts the operation
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "abort");
        repeat (2) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (8) @(negedge clk);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);
        check("abort_late_busy", {31'd0, busy}, 32'd0);

        // reset beats a simultaneous mthi
        reset = 1'b1;
        start = 1'b1;
        MDUop = 4'd5;
        srcA  = 32'h0000_BEEF;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        MDUop = 4'd0;
        check("rst_prio_hi", hi, 32'd0);
        check("rst_prio_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
